// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: opcode macros, default widths and the per-cycle action decode.
// The opcode macros are global so decode/control can share them.
`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define OP_CODE_BITS 6
`define OP_CODE_HALT 6'b111111
`endif

package fetch_unit_pkg;

  localparam int unsigned DefaultAddrWidth  = 16;
  localparam int unsigned DefaultInstrWidth = 32;

  typedef enum logic [1:0] {
    ActReset,
    ActRedirect,
    ActStall,
    ActAdvance
  } fetch_act_e;

  // Reset beats redirect, redirect beats stall.
  function automatic fetch_act_e decode_act(logic reset, logic redirect, logic stall);
    if (reset) begin
      return ActReset;
    end else if (redirect) begin
      return ActRedirect;
    end else if (stall) begin
      return ActStall;
    end
    return ActAdvance;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register: catches the word returning while decode stalls, so it is
// never lost; drained on the next advance, dropped on redirect/reset.
module fetch_skid_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned INSTR_WIDTH = DefaultInstrWidth
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   capture,
  input  logic                   drain,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [ADDR_WIDTH-1:0]  in_pc,
  output logic                   hold_valid,
  output logic [INSTR_WIDTH-1:0] hold_instr,
  output logic [ADDR_WIDTH-1:0]  hold_pc
);

  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  assign hold_valid = valid_q;
  assign hold_instr = instr_q;
  assign hold_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-flight read tracking and the IF/ID register.
// Define FETCH_HALT_EN to stop fetching once a HALT opcode reaches IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned          INSTR_WIDTH = DefaultInstrWidth,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  output logic                     imem_rd_en,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     if_id_valid,
  output logic [INSTR_WIDTH-1:0]   if_id_instr,
  output logic [ADDR_WIDTH-1:0]    if_id_pc,
  output logic [`OP_CODE_BITS-1:0] if_id_opcode,
  output logic                     halted
);

  fetch_act_e act;

  logic [ADDR_WIDTH-1:0]  pc_q;
  logic                   req_valid_q;
  logic [ADDR_WIDTH-1:0]  req_pc_q;
  logic                   if_id_valid_q;
  logic [INSTR_WIDTH-1:0] if_id_instr_q;
  logic [ADDR_WIDTH-1:0]  if_id_pc_q;

  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0]  hold_pc;

  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_instr;
  logic [ADDR_WIDTH-1:0]  load_pc;
  logic                   halt_load;

  assign act        = decode_act(reset, redirect, stall);
  assign imem_rd_en = !stall && !halted;
  assign imem_addr  = pc_q;

  fetch_skid_buf #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_skid (
    .clk        (clk),
    .clear      ((act == ActReset) || (act == ActRedirect)),
    .capture    ((act == ActStall) && req_valid_q),
    .drain      (act == ActAdvance),
    .in_instr   (imem_rdata),
    .in_pc      (req_pc_q),
    .hold_valid (hold_valid),
    .hold_instr (hold_instr),
    .hold_pc    (hold_pc)
  );

  // Skid entry is always older than the in-flight read, so it goes first.
  always_comb begin
    load_valid = 1'b0;
    load_instr = if_id_instr_q;
    load_pc    = if_id_pc_q;
    if (hold_valid) begin
      load_valid = 1'b1;
      load_instr = hold_instr;
      load_pc    = hold_pc;
    end else if (req_valid_q) begin
      load_valid = 1'b1;
      load_instr = imem_rdata;
      load_pc    = req_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    unique case (act)
      ActReset: begin
        pc_q          <= RESET_PC;
        req_valid_q   <= 1'b0;
        req_pc_q      <= '0;
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= '0;
        if_id_pc_q    <= '0;
      end
      ActRedirect: begin
        pc_q          <= redirect_pc;
        req_valid_q   <= 1'b0;
        if_id_valid_q <= 1'b0;
      end
      ActStall: begin
        req_valid_q <= 1'b0;
      end
      ActAdvance: begin
        if_id_valid_q <= load_valid;
        if_id_instr_q <= load_instr;
        if_id_pc_q    <= load_pc;
        if (imem_rd_en) begin
          req_pc_q    <= pc_q;
          pc_q        <= pc_q + ADDR_WIDTH'(1);
          req_valid_q <= !halt_load;
        end else begin
          req_valid_q <= 1'b0;
        end
      end
    endcase
  end

`ifdef FETCH_HALT_EN
  logic halted_q;

  assign halt_load = load_valid && (load_instr[INSTR_WIDTH-1 -: `OP_CODE_BITS] == `OP_CODE_HALT);

  always_ff @(posedge clk) begin
    if ((act == ActReset) || (act == ActRedirect)) begin
      halted_q <= 1'b0;
    end else if ((act == ActAdvance) && halt_load) begin
      halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  assign halt_load = 1'b0;
  assign halted    = 1'b0;
`endif

  assign if_id_valid  = if_id_valid_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_opcode = if_id_instr_q[INSTR_WIDTH-1 -: `OP_CODE_BITS];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed
// literal expectations around reset, stall, redirect, PC wrap and HALT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [5:0]  if_id_opcode;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic        check_en  = 1'b0;
  logic        halt_on   = 1'b0;
  logic [15:0] halt_addr = 16'd3;

  // Reference model: addresses requested but not yet delivered, in order.
  logic [15:0] m_pend[$];
  logic [15:0] m_next_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [15:0] m_pc;
  logic        m_halted;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_opcode (if_id_opcode),
    .halted       (halted)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (halt_on && (a == halt_addr)) return {6'h3f, 10'h000, a};
    return 32'h1000 + {16'h0000, a};
  endfunction

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pend.delete();
      m_next_pc = 16'h0000;
      m_valid   = 1'b0;
      m_instr   = 32'h0;
      m_pc      = 16'h0000;
      m_halted  = 1'b0;
    end else if (redirect) begin
      m_pend.delete();
      m_next_pc = redirect_pc;
      m_valid   = 1'b0;
      m_halted  = 1'b0;
    end else if (!stall) begin
      if (m_pend.size() > 0) begin
        m_pc    = m_pend.pop_front();
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (!m_halted) begin
        m_pend.push_back(m_next_pc);
        m_next_pc = m_next_pc + 16'd1;
      end
`ifdef FETCH_HALT_EN
      if (m_valid && (m_instr[31:26] == 6'h3f)) begin
        m_halted = 1'b1;
        m_pend.delete();
      end
`endif
    end
  endtask

  // Inputs change 2 time units after each rising edge; model steps on the edge itself.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("if_id_pc", 32'(if_id_pc), 32'(m_pc));
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_opcode", 32'(if_id_opcode), 32'(m_instr[31:26]));
      check("imem_addr", 32'(imem_addr), 32'(m_next_pc));
      check("imem_rd_en", 32'(imem_rd_en), 32'(!stall && !m_halted));
      check("halted", 32'(halted), 32'(m_halted));
    end
  end

  initial begin
    logic [15:0] pattern;
    pattern     = 16'b0110_1001_1100_0101;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    tick();
    check_en = 1'b1;
    tick();
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_pc", 32'(if_id_pc), 32'd0);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    reset = 1'b0;

    tick();  // E0: read of pc 0 issued
    tick();  // E1
    check("e1_valid", 32'(if_id_valid), 32'd1);
    check("e1_pc", 32'(if_id_pc), 32'd0);
    check("e1_instr", if_id_instr, 32'h0000_1000);
    tick();
    check("e2_pc", 32'(if_id_pc), 32'd1);
    tick();
    tick();
    check("e4_pc", 32'(if_id_pc), 32'd3);
    tick();  // IF/ID pc 4, pc 5 in flight

    stall = 1'b1;
    tick();
    check("stall1_pc", 32'(if_id_pc), 32'd4);
    tick();
    tick();
    check("stall3_pc", 32'(if_id_pc), 32'd4);
    check("stall3_valid", 32'(if_id_valid), 32'd1);
    stall = 1'b0;
    tick();
    check("release_pc", 32'(if_id_pc), 32'd5);
    tick();
    check("release_next_pc", 32'(if_id_pc), 32'd6);
    tick();
    check("pre_redir_pc", 32'(if_id_pc), 32'd7);

    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("redir_bubble1", 32'(if_id_valid), 32'd0);
    tick();
    check("redir_bubble2", 32'(if_id_valid), 32'd0);
    tick();
    check("redir_target", 32'(if_id_pc), 32'h40);
    check("redir_instr", if_id_instr, 32'h0000_1040);
    tick();
    check("redir_next", 32'(if_id_pc), 32'h41);

    // Fill the skid, then redirect while still stalled.
    stall = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    check("rs_bubble", 32'(if_id_valid), 32'd0);
    tick();
    check("rs_target", 32'(if_id_pc), 32'h80);
    check("rs_valid", 32'(if_id_valid), 32'd1);

    redirect    = 1'b1;
    redirect_pc = 16'hfffe;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check("wrap_fffe", 32'(if_id_pc), 32'hfffe);
    check("wrap_addr", 32'(imem_addr), 32'h0000);
    tick();
    check("wrap_ffff", 32'(if_id_pc), 32'hffff);
    tick();
    check("wrap_0000", 32'(if_id_pc), 32'h0000);
    check("wrap_instr", if_id_instr, 32'h0000_1000);

    for (int i = 0; i < 16; i++) begin
      stall = pattern[i];
      tick();
    end
    stall = 1'b0;
    tick();
    tick();

    stall = 1'b1;
    reset = 1'b1;
    tick();
    check("rst_in_stall", 32'(if_id_valid), 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    check("restart_pc", 32'(if_id_pc), 32'd0);

    halt_on = 1'b1;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();  // E0
    repeat (4) tick();  // E4 loads pc 3
    check("halt_pc", 32'(if_id_pc), 32'd3);
    check("halt_opcode", 32'(if_id_opcode), 32'h3f);
`ifdef FETCH_HALT_EN
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    check("halt_bubble", 32'(if_id_valid), 32'd0);
    tick();
    check("halt_sticky", 32'(halted), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_rd_en_back", 32'(imem_rd_en), 32'd1);
    tick();
    tick();
    check("halt_restart_pc", 32'(if_id_pc), 32'd0);
    check("halt_restart_valid", 32'(if_id_valid), 32'd1);
`else
    check("halt_off_flag", 32'(halted), 32'd0);
    tick();
    check("halt_off_next", 32'(if_id_pc), 32'd4);
    check("halt_off_valid", 32'(if_id_valid), 32'd1);
`endif

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage: owns the program counter and issues word reads to a synchronous instruction memory.
- Registers each returned instruction and its PC into the IF/ID pipeline register.
- Exposes the opcode field directly to the decode/control stage.
- Supports a decode-side stall, branch/jump redirect from execute, and a one-entry skid buffer so no fetched word is lost while stalled.

## Interface
- ADDR_WIDTH, 16, word-address width of PC and instruction memory
- INSTR_WIDTH, 32, instruction width; opcode is the top `OP_CODE_BITS bits
- RESET_PC, 0, PC loaded on reset
- clk  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  decode cannot accept; hold IF/ID and PC
- redirect  input  1  taken jump/branch from execute
- redirect_pc  input  ADDR_WIDTH  target PC, valid with redirect
- imem_addr  output  ADDR_WIDTH  read address (= pc register)
- imem_rd_en  output  1  read request this cycle
- imem_rdata  input  INSTR_WIDTH  data for request issued previous cycle
- if_id_valid  output  1  IF/ID holds a live instruction
- if_id_instr  output  INSTR_WIDTH  fetched instruction
- if_id_pc  output  ADDR_WIDTH  its address
- if_id_opcode  output  `OP_CODE_BITS  if_id_instr[INSTR_WIDTH-1 -: `OP_CODE_BITS], to decode
- halted  output  1  fetch stopped on HALT (0 when feature compiled out)

## Operation
- State: pc, req_valid/req_pc (in-flight read), hold_valid/hold_instr/hold_pc (skid), IF/ID register, halted.
- imem_rd_en = !stall && !halted (combinational).
- Priority per cycle: reset > redirect > stall > advance.
- Reset: pc=RESET_PC; req_valid, hold_valid, if_id_valid, halted = 0; if_id_instr, if_id_pc = 0.
- Redirect: pc<=redirect_pc; req_valid, hold_valid, if_id_valid, halted <= 0. Any read issued this cycle or returning this cycle is discarded. Redirect overrides a simultaneous stall.
- Stall: pc and IF/ID unchanged. If req_valid: hold <= {imem_rdata, req_pc}, hold_valid<=1. req_valid<=0. No new read.
- Advance:
  - IF/ID <= hold if hold_valid, else {imem_rdata, req_pc} if req_valid, else bubble (if_id_valid=0, data unchanged).
  - hold_valid<=0.
  - If imem_rd_en: req_pc<=pc, pc<=pc+1, req_valid<=1; otherwise req_valid<=0.
- hold_valid and req_valid are never both 1.
- PC arithmetic: unsigned ADDR_WIDTH, +1 per read, wraps 2^ADDR_WIDTH-1 -> 0.

## Timing
- Reset released before edge E0: read of RESET_PC issued in cycle 0; if_id_valid=1 with that instruction after E1. Thereafter one instruction per cycle with no stalls.
- Redirect sampled at edge T: target read in cycle T+1; target instruction in IF/ID after edge T+2. if_id_valid=0 after edge T and after edge T+1 (two-bubble penalty).
- Stall of N cycles: IF/ID frozen N cycles. On release, the held word enters IF/ID at the first advance edge while the next read issues the same cycle. No bubble and no duplicate.
- Reset during stall or redirect: reset wins; all valids cleared.

## Configuration
- FETCH_HALT_EN defined: when an instruction with opcode `OP_CODE_HALT (6'b111111) is loaded into IF/ID:
  - halted<=1 and req_valid<=0, discarding the read issued that cycle.
  - imem_rd_en stays 0.
  - The next advance loads a bubble.
  - Only reset or redirect clears halted.
- FETCH_HALT_EN undefined: HALT is treated as an ordinary instruction; halted tied 0.

## Structure
- Shared defines package: `OP_CODE_BITS, `OP_CODE_HALT, and the default address/instruction widths.
- Sub-module fetch_skid_buf holds the one-entry hold register: capture on stall, drain on advance, clear on redirect/reset.
- fetch_unit keeps the PC, request tracking and IF/ID register.

## Test plan
- Reset, no stall, memory word k = 0x1000+k -> after E1 IF/ID = {0x1000, pc 0}; then pc 1, 2, 3 on consecutive edges, if_id_valid continuously 1.
- Stall for 3 cycles while pc 5 is in flight -> IF/ID holds pc 4 for all 3 cycles; after release IF/ID shows pc 5 then pc 6, no gap, no repeat.
- Redirect to 0x0040 while IF/ID holds pc 7 -> two bubbles, then pc 0x0040, then 0x0041.
- Redirect and stall asserted together with hold_valid=1 -> hold discarded; target arrives 2 edges later.
- pc=0xFFFF (ADDR_WIDTH 16) -> next fetch address 0x0000.
- FETCH_HALT_EN, HALT at pc 3 -> halted=1 once pc 3 is in IF/ID, imem_rd_en=0, next IF/ID is a bubble; redirect to 0 clears halted and fetch restarts at 0.
